// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: burst reader for a fixed-latency weight ROM. Returned words
// land in a small FIFO that feeds a valid/ready stream, guarded by read credits.
//
// state    | meaning
// S_IDLE   | waiting for start; first read issues on the accepting edge
// S_ISSUE  | issuing reads while FIFO credit is available
// S_DRAIN  | all reads issued, waiting for the last word to be popped
// S_FINISH | one-cycle done pulse, then back to idle
module weight_fetch_ctrl #(
   parameter int RAM_WIDTH   = 8,
   parameter int RAM_DEPTH   = 1024,
   parameter int ROM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4,
   localparam int AW = $clog2(RAM_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [CW-1:0]        num_words,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        rom_addr,
   input  logic [RAM_WIDTH-1:0] rom_data,
   output logic [RAM_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int FCW = PW + 1;
   localparam int SW  = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

   state_t                 r_state;
   logic [AW-1:0]          r_base;
   logic [CW-1:0]          r_num;
   logic [CW-1:0]          r_issued;
   logic [CW-1:0]          r_delivered;
   logic [ROM_LATENCY-1:0] r_tag;
   logic                   r_ret;
   logic                   r_busy;
   logic                   r_done;
   logic [AW-1:0]          r_rom_addr;
   logic [RAM_WIDTH-1:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [FCW-1:0]         r_count;

   logic          w_pop;
   logic          w_push;
   logic [SW-1:0] w_inflight;
   logic          w_can_issue;
   logic          w_issue;
   logic          w_start_issue;
   logic [CW-1:0] w_deliv_next;

   assign out_valid = (r_count != '0);
   assign out_data  = r_mem[r_rd_ptr];
   assign out_last  = out_valid && (r_delivered == (r_num - CW'(1)));
   assign busy      = r_busy;
   assign done      = r_done;
   assign rom_addr  = r_rom_addr;

   assign w_pop        = out_valid && out_ready;
   assign w_push       = r_ret;
   assign w_deliv_next = r_delivered + CW'(w_pop);

   // Outstanding reads include the one whose data is on rom_data right now
   // (r_ret); it is not in r_count until this edge.
   always_comb begin
      w_inflight = SW'(r_ret);
      for (int i = 0; i < ROM_LATENCY; i++) begin
         w_inflight = w_inflight + SW'(r_tag[i]);
      end
   end

   assign w_can_issue   = (SW'(r_count) + w_inflight - SW'(w_pop)) < SW'(FIFO_DEPTH);
   assign w_issue       = (r_state == S_ISSUE) && (r_issued != r_num) && w_can_issue;
   assign w_start_issue = (r_state == S_IDLE) && start && (num_words != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag <= '0;
         r_ret <= 1'b0;
      end else begin
         r_tag <= (r_tag << 1) | ROM_LATENCY'(w_issue || w_start_issue);
         r_ret <= r_tag[ROM_LATENCY-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= rom_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + FCW'(w_push) - FCW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_num       <= '0;
         r_issued    <= '0;
         r_delivered <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rom_addr  <= '0;
      end else begin
         r_done      <= 1'b0;
         r_delivered <= w_deliv_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base      <= base_addr;
                  r_num       <= num_words;
                  r_delivered <= '0;
                  if (num_words == '0) begin
                     r_issued <= '0;
                     r_done   <= 1'b1;
                     r_state  <= S_FINISH;
                  end else begin
                     r_issued   <= CW'(1);
                     r_rom_addr <= base_addr;
                     r_busy     <= 1'b1;
                     r_state    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (w_issue) begin
                  r_rom_addr <= r_base + r_issued[AW-1:0];
                  r_issued   <= r_issued + CW'(1);
               end
               if (r_issued == r_num) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_deliv_next == r_num) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && (r_count == FCW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a 2-cycle registered ROM model
// holding mem[i] = i[7:0].
module tb_weight_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] num_words;
   logic        busy;
   logic        done;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   logic [7:0]  rom_mem [1024];
   logic [7:0]  rom_p1;

   int n_pass  = 0;
   int n_total = 0;

   weight_fetch_ctrl #(
      .RAM_WIDTH(8), .RAM_DEPTH(1024), .ROM_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_words(num_words), .busy(busy), .done(done), .rom_addr(rom_addr),
      .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rom_p1   <= rom_mem[rom_addr];
      rom_data <= rom_p1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0;
      for (int i = 0; i < 1024; i++) rom_mem[i] = 8'(i);
      tick(); tick();
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
      n_total++; if (out_last !== 1'b0) $display("FAIL reset_last got %b exp 0", out_last); else n_pass++;
      n_total++; if (rom_addr !== 10'd0) $display("FAIL reset_addr got %0d exp 0", rom_addr); else n_pass++;
      n_total++; if (out_data !== 8'd0) $display("FAIL reset_data got %0d exp 0", out_data); else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic e;
      tick();
      base_addr = 10'd10; num_words = 11'd5; start = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         start = 1'b0;
         e = (c >= 1 && c <= 8);
         n_total++; if (busy !== e) $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, e); else n_pass++;
         e = (c == 9);
         n_total++; if (done !== e) $display("FAIL basic_done c=%0d got %b exp %b", c, done, e); else n_pass++;
         e = (c >= 4 && c <= 8);
         n_total++; if (out_valid !== e) $display("FAIL basic_valid c=%0d got %b exp %b", c, out_valid, e); else n_pass++;
         e = (c == 8);
         n_total++; if (out_last !== e) $display("FAIL basic_last c=%0d got %b exp %b", c, out_last, e); else n_pass++;
         if (c >= 4 && c <= 8) begin
            n_total++;
            if (out_data !== 8'(6 + c)) $display("FAIL basic_data c=%0d got %0d exp %0d", c, out_data, 6 + c);
            else n_pass++;
         end
         if (c <= 5) begin
            n_total++;
            if (rom_addr !== 10'(9 + c)) $display("FAIL basic_addr c=%0d got %0d exp %0d", c, rom_addr, 9 + c);
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      int  k = 0;
      bit  done_seen = 0;
      tick();
      base_addr = 10'd0; num_words = 11'd16; start = 1'b1; out_ready = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         start = 1'b0;
         if (c == 6 || c == 20) begin
            n_total++; if (rom_addr !== 10'd3) $display("FAIL bp_addr_stall c=%0d got %0d exp 3", c, rom_addr); else n_pass++;
         end
      end
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b exp 1", out_valid); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL bp_busy got %b exp 1", busy); else n_pass++;
      n_total++; if (out_data !== 8'd0) $display("FAIL bp_head got %0d exp 0", out_data); else n_pass++;
      out_ready = 1'b1;
      for (int n = 0; n < 60 && !done_seen; n++) begin
         if (n > 0) tick();
         if (done) done_seen = 1;
         if (out_valid) begin
            n_total++; if (out_data !== 8'(k)) $display("FAIL bp_data k=%0d got %0d exp %0d", k, out_data, k); else n_pass++;
            n_total++; if (out_last !== (k == 15)) $display("FAIL bp_last k=%0d got %b exp %b", k, out_last, (k == 15)); else n_pass++;
            k++;
         end
      end
      n_total++; if (k != 16) $display("FAIL bp_count got %0d exp 16", k); else n_pass++;
      n_total++; if (!done_seen) $display("FAIL bp_done got 0 exp 1"); else n_pass++;
   endtask

   task automatic test_wrap();
      int k = 0;
      int ndone = 0;
      int after = 0;
      tick();
      base_addr = 10'd1020; num_words = 11'd8; start = 1'b1; out_ready = 1'($urandom_range(0, 1));
      for (int n = 0; n < 200 && after < 4; n++) begin
         tick();
         start = 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         if (ndone > 0) after++;
         if (done) ndone++;
         if (out_valid && out_ready) begin
            n_total++; if (out_data !== 8'(1020 + k)) $display("FAIL wrap_data k=%0d got %0d exp %0d", k, out_data, 8'(1020 + k)); else n_pass++;
            n_total++; if (out_last !== (k == 7)) $display("FAIL wrap_last k=%0d got %b exp %b", k, out_last, (k == 7)); else n_pass++;
            k++;
         end
      end
      n_total++; if (k != 8) $display("FAIL wrap_count got %0d exp 8", k); else n_pass++;
      n_total++; if (ndone != 1) $display("FAIL wrap_done_pulses got %0d exp 1", ndone); else n_pass++;
      out_ready = 1'b1;
   endtask

   task automatic test_zero();
      tick();
      base_addr = 10'd500; num_words = 11'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (done !== 1'b1) $display("FAIL zero_done got %b exp 1", done); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL zero_busy got %b exp 0", busy); else n_pass++;
      for (int c = 2; c <= 7; c++) begin
         tick();
         n_total++; if (done !== 1'b0) $display("FAIL zero_done_after c=%0d got %b exp 0", c, done); else n_pass++;
         n_total++; if (out_valid !== 1'b0) $display("FAIL zero_valid c=%0d got %b exp 0", c, out_valid); else n_pass++;
         n_total++; if (rom_addr !== 10'd3) $display("FAIL zero_addr c=%0d got %0d exp 3", c, rom_addr); else n_pass++;
      end
   endtask

   task automatic test_ignore_start();
      int  k = 0;
      logic e;
      tick();
      base_addr = 10'd20; num_words = 11'd3; start = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         start = (c == 2 || c == 7);
         base_addr = start ? 10'd100 : 10'd20;
         num_words = start ? 11'd5 : 11'd3;
         e = (c >= 1 && c <= 6);
         n_total++; if (busy !== e) $display("FAIL ign_busy c=%0d got %b exp %b", c, busy, e); else n_pass++;
         e = (c == 7);
         n_total++; if (done !== e) $display("FAIL ign_done c=%0d got %b exp %b", c, done, e); else n_pass++;
         if (out_valid) begin
            n_total++; if (out_data !== 8'(20 + k)) $display("FAIL ign_data k=%0d got %0d exp %0d", k, out_data, 20 + k); else n_pass++;
            k++;
         end
      end
      n_total++; if (k != 3) $display("FAIL ign_count got %0d exp 3", k); else n_pass++;
      tick();
      base_addr = 10'd40; num_words = 11'd2; start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         start = 1'b0;
         e = (c == 4 || c == 5);
         n_total++; if (out_valid !== e) $display("FAIL ign2_valid c=%0d got %b exp %b", c, out_valid, e); else n_pass++;
         if (e) begin
            n_total++; if (out_data !== 8'(36 + c)) $display("FAIL ign2_data c=%0d got %0d exp %0d", c, out_data, 36 + c); else n_pass++;
         end
         e = (c == 5);
         n_total++; if (out_last !== e) $display("FAIL ign2_last c=%0d got %b exp %b", c, out_last, e); else n_pass++;
         e = (c == 6);
         n_total++; if (done !== e) $display("FAIL ign2_done c=%0d got %b exp %b", c, done, e); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic e;
      tick();
      base_addr = 10'd50; num_words = 11'd6; start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", out_valid); else n_pass++;
      n_total++; if (rom_addr !== 10'd0) $display("FAIL rmid_addr got %0d exp 0", rom_addr); else n_pass++;
      n_total++; if (out_data !== 8'd0) $display("FAIL rmid_data got %0d exp 0", out_data); else n_pass++;
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_stale c=%0d got %b exp 0", c, out_valid); else n_pass++;
         n_total++; if (done !== 1'b0) $display("FAIL rmid_nodone c=%0d got %b exp 0", c, done); else n_pass++;
      end
      base_addr = 10'd3; num_words = 11'd2; start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         start = 1'b0;
         e = (c == 4 || c == 5);
         n_total++; if (out_valid !== e) $display("FAIL rnew_valid c=%0d got %b exp %b", c, out_valid, e); else n_pass++;
         if (e) begin
            n_total++; if (out_data !== 8'(c - 1)) $display("FAIL rnew_data c=%0d got %0d exp %0d", c, out_data, c - 1); else n_pass++;
         end
         e = (c == 6);
         n_total++; if (done !== e) $display("FAIL rnew_done c=%0d got %b exp %b", c, done, e); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero();
      test_ignore_start();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Sequences burst reads from the single-port weight ROM, which has a fixed 2-cycle registered read latency and no enable.
- On a start command it issues ROM_LATENCY-tagged reads for a contiguous address range, beginning at a base address, and buffers returned words in a small FIFO.
- The FIFO drives a valid/ready stream to the downstream binary-neuron datapath.
- A credit scheme ensures in-flight reads can never overflow the FIFO under downstream backpressure.

Parameters:
- RAM_WIDTH, 8, ROM word width in bits.
- RAM_DEPTH, 1024, ROM depth in words. AW = $clog2(RAM_DEPTH).
- ROM_LATENCY, 2, cycles from rom_addr to matching rom_data.
- FIFO_DEPTH, 4, output buffer entries. Must be a power of 2 and ≥ ROM_LATENCY+2.
- Derived: CW = AW+1, the count width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe. Ignored while busy.
- base_addr  in  AW  first ROM address of the burst.
- num_words  in  CW  burst length, 0..RAM_DEPTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the burst is complete.
- rom_addr  out  AW  registered address to the ROM's addr_rd.
- rom_data  in  RAM_WIDTH  ROM data_out.
- out_data  out  RAM_WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with out_valid on the final word of the burst.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - busy, done, out_valid, out_last = 0; rom_addr = 0; out_data = 0.
  - FIFO emptied, tag pipeline cleared, counters cleared.
  - Reset mid-burst aborts the burst; no done pulse follows.
- FSM states:
  - IDLE: start=1 latches base_addr and num_words. Goes to ISSUE, or to FINISH if num_words==0.
  - ISSUE: issues reads until issued==num_words, then goes to DRAIN.
  - DRAIN: waits until delivered==num_words, then goes to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0, then returns to IDLE.
  - A start coincident with FINISH is ignored.
- Issue rule:
  - In ISSUE, a read is issued in cycle c iff fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of set bits in a ROM_LATENCY-deep tag shift register.
  - An issue registers rom_addr = base_addr + issued (mod RAM_DEPTH, natural AW wrap) and pushes tag=1. Otherwise tag=0.
  - rom_addr holds its last value when not issuing.
- Return path:
  - A tag reaching the end of the delay line means rom_data in that cycle matches that read; it is written to the FIFO at the clock edge.
  - Tag alignment: rom_addr valid in cycle c implies rom_data valid in cycle c+ROM_LATENCY.
- Output:
  - A pop occurs on out_valid & out_ready. Simultaneous push and pop is allowed; count is unchanged.
  - FIFO is never written when full. The credit rule guarantees this, and it is asserted in simulation.
  - out_last = out_valid & (delivered == num_words-1).
- Latency: start in cycle 0 → rom_addr=base in cycle 1 → data in the FIFO, out_valid=1 in cycle 4.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Counters issued and delivered are CW bits wide, so num_words=RAM_DEPTH reads the whole ROM once, wrapping the address.

Test Plan:
- ROM init mem[i]=i[7:0]; start, base=10, num=5, out_ready=1 → out_valid cycles 4..8 with data 10..14; out_last in cycle 8; done in cycle 9; busy cycles 1..8.
- out_ready=0 for 20 cycles after start, base=0, num=16 → exactly 4 words buffered; rom issues stop after 4 tags; no overflow; releasing ready yields 0..15 in order with no gaps or duplicates.
- Random out_ready (50%), base=1020, num=8, RAM_DEPTH=1024 → data 252..255,0..3, i.e. addresses 1020..1023 then 0..3; out_last only on the 8th word; one done pulse.
- num_words=0 → no out_valid, no rom issue tags; done pulses once in the cycle after start.
- start re-asserted while busy with different base → ignored; the original stream completes unchanged; a subsequent start after done is accepted.
- rst_n asserted mid-burst with 2 reads in flight → outputs zero immediately (asynchronously); after release, no stale words appear and a new burst, base=3, num=2, returns 3,4.
